drv_segment_scan: RTL
=====================

# drv_segment_scan

Time-multiplexed scanner for a common-anode multi-digit 7-segment display. It latches a packed hexadecimal value through a load handshake and commits it only at frame boundaries, so the display never shows a torn value. It drives one digit at a time: an active-low anode strobe plus a 5-bit digit code that feeds `drv_segment_hex` directly downstream. Codes 0x00–0x0F select hex glyphs; 0x10 is the blank code, which the decoder renders as all segments off.

## Interface
- `DIGITS`, default 8: number of display digits, 2..16.
- `DIV`, default 50_000: clock cycles per digit slot, ≥ 2.
- `i_clk` input 1: sole clock, rising edge.
- `i_rst_n` input 1: asynchronous, active-low reset.
- `i_value` input 4*DIGITS: packed nibbles; nibble k (bits 4k+3:4k) drives digit k; digit 0 is least significant.
- `i_load` input 1: capture `i_value` into the shadow register this cycle.
- `i_enable` input 1: scan enable.
- `o_anode` output DIGITS: active-low digit strobes; at most one bit is low.
- `o_digit` output 5: code for `drv_segment_hex`; 0x10 = blank.
- `o_ack` output 1: one-cycle pulse when a loaded value is committed to display.

## Operation
- State:
  - prescaler `cnt`, width $clog2(DIV);
  - digit index `idx`, width $clog2(DIGITS);
  - shadow register and display register, each 4*DIGITS;
  - `pending` flag.
- Tick: `cnt == DIV-1`.
  - On a tick edge, `cnt` is set to 0 and `idx` becomes `(idx+1) mod DIGITS`.
  - On other edges, `cnt` increments.
- Load: if `i_load` is sampled high, shadow takes `i_value` and `pending` is set to 1. Repeated loads overwrite shadow; only the last one is committed.
- Commit happens on the tick edge where `idx` wraps from DIGITS-1 to 0, when `pending` is 1:
  - display takes shadow;
  - `pending` clears;
  - `o_ack` is 1 for that edge only.
- Load coinciding with commit edge:
  - the old shadow is committed and `o_ack` pulses;
  - the new value is captured, and `pending` stays 1 for the next frame.
- Outputs are registered and updated on every tick edge from the new `idx`:
  - `o_anode` = all ones except bit `idx` = 0;
  - `o_digit` = {1'b0, display nibble `idx`}.
  - On a commit edge, the outputs use the newly committed value (bypass).
- `i_enable` low:
  - `cnt` and `idx` are held at 0;
  - `o_anode` is all ones and `o_digit` is 0x10;
  - if `pending`, commit happens on the next edge with an `o_ack` pulse.
- `i_enable` rising: the scan restarts, and the first tick lands DIV cycles later at digit 1 (`idx` 0→1).

## Timing
- Reset values:
  - `cnt` 0, `idx` 0, shadow 0, display 0, `pending` 0;
  - `o_anode` all ones, `o_digit` 0x10, `o_ack` 0.
- Reset is effective immediately, including mid-frame or with `pending` set. The pending load is discarded and no `o_ack` is produced.
- First tick after reset release: the DIV-th rising edge. At that edge `idx` goes 0→1, and `o_anode` bit 1 goes low.
- Digit slot length: exactly DIV cycles. Frame length: DIGITS*DIV cycles.
- Load-to-display latency is at most one frame plus one tick, and at least 1 cycle (enable low).
- `o_ack` is never asserted for two consecutive cycles unless enable is low and loads are back-to-back.

## Configuration
- Macro: `DRV_SEGMENT_SCAN_BLANK_EN`.
- Defined: leading-zero blanking.
  - Digit k ≥ 1 outputs 0x10 when display nibbles DIGITS-1 down to k are all zero.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - Evaluated on the same edge as the registered output.
- Undefined: every digit outputs its hex nibble, and code 0x10 appears only when idle or in reset.

## Test plan
- DIGITS=4, DIV=4, reset, enable=1, no load:
  - first tick at edge 4 gives `o_anode`=4'b1101, `o_digit`=0x00;
  - `o_anode` steps 1011, 0111, 1110 every 4 cycles.
- Load 0x1A2F with the scan at `idx`=1:
  - `o_digit` stays 0 until the wrap edge;
  - at that edge `o_ack`=1 for one cycle and `o_digit`=0x0F on 4'b1110;
  - then 0x02, 0x0A, 0x01.
- Load 0x1111 then 0x2222 in the same frame: a single `o_ack`, and the display shows 0x02 on all digits.
- Load asserted on the commit edge (old shadow 0x0005, new 0x0007):
  - `o_ack` pulses and 0x0005 is shown;
  - a second `o_ack` follows one frame later and 0x0007 is shown.
- `i_enable`=0 with load 0x00C3:
  - `o_ack` fires on the next edge, `o_anode`=4'b1111, `o_digit`=0x10;
  - re-enable, and `o_digit`=0x0C appears 4 cycles later on 4'b1101.
- With `DRV_SEGMENT_SCAN_BLANK_EN`, value 0x0030: digit 3 → 0x10, digit 2 → 0x10, digit 1 → 0x03, digit 0 → 0x00. Then assert reset mid-frame: the outputs return immediately to all ones / 0x10.

Source files
------------

// File: rtl/drv_segment_scan.sv
// Time-multiplexed common-anode 7-segment scanner with frame-aligned commit of a shadowed value.
// Define DRV_SEGMENT_SCAN_BLANK_EN to enable leading-zero blanking.
module drv_segment_scan #(
  parameter int unsigned DIGITS = 8,
  parameter int unsigned DIV    = 50_000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [4*DIGITS-1:0]   i_value,
  input  logic                  i_load,
  input  logic                  i_enable,
  output logic [DIGITS-1:0]     o_anode,
  output logic [4:0]            o_digit,
  output logic                  o_ack
);

  localparam int unsigned CntW = $clog2(DIV);
  localparam int unsigned IdxW = $clog2(DIGITS);
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(DIGITS - 1);
  localparam logic [4:0] BlankCode = 5'h10;

  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic                pending_q, pending_d;
  logic [DIGITS-1:0]   anode_q, anode_d;
  logic [4:0]          digit_q, digit_d;
  logic                ack_q, ack_d;

  logic tick;
  logic wrap;
  logic commit;
  logic suppress;
  logic [3:0] nibble;

  always_comb begin
    tick   = i_enable && (cnt_q == CntMax);
    wrap   = tick && (idx_q == IdxMax);
    // While disabled there is no frame to tear, so a pending value commits at once.
    commit = pending_q && (wrap || !i_enable);
  end

  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (!i_enable) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (tick) begin
      cnt_d = '0;
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    disp_d    = commit ? shadow_q : disp_q;
    shadow_d  = i_load ? i_value : shadow_q;
    // A load on the commit edge keeps pending set for the following frame.
    pending_d = i_load || (pending_q && !commit);
    ack_d     = commit;
  end

  assign nibble = disp_d[{idx_d, 2'b00} +: 4];

`ifdef DRV_SEGMENT_SCAN_BLANK_EN
  logic [DIGITS-1:0] lead_zero;

  // lead_zero[k]: nibbles DIGITS-1 down to k of the display value are all zero.
  always_comb begin
    logic run;
    run       = 1'b1;
    lead_zero = '0;
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
      run          = run && (disp_d[4*k +: 4] == 4'h0);
      lead_zero[k] = run;
    end
  end

  assign suppress = (idx_d != '0) && lead_zero[idx_d];
`else
  assign suppress = 1'b0;
`endif

  always_comb begin
    anode_d = anode_q;
    digit_d = digit_q;
    if (!i_enable) begin
      anode_d = '1;
      digit_d = BlankCode;
    end else if (tick) begin
      anode_d = ~(DIGITS'(1) << idx_d);
      digit_d = suppress ? BlankCode : {1'b0, nibble};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
      anode_q   <= '1;
      digit_q   <= BlankCode;
      ack_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      anode_q   <= anode_d;
      digit_q   <= digit_d;
      ack_q     <= ack_d;
    end
  end

  assign o_anode = anode_q;
  assign o_digit = digit_q;
  assign o_ack   = ack_q;

endmodule
